// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Phase codes are {a,b}; forward order is 00,10,11,01.
package quad_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } fsm_t;

  localparam logic [1:0] PH00 = 2'b00;
  localparam logic [1:0] PH10 = 2'b10;
  localparam logic [1:0] PH11 = 2'b11;
  localparam logic [1:0] PH01 = 2'b01;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } step_t;

  function automatic logic [1:0] next_fwd(
    input logic [1:0] p
  );
    logic [1:0] n;
    case (p)
      PH00:    n = PH10;
      PH10:    n = PH11;
      PH11:    n = PH01;
      default: n = PH00;
    endcase
    return n;
  endfunction

  function automatic step_t step_decode(
    input logic [1:0] prev,
    input logic [1:0] curr
  );
    step_t r;
    r = '0;
    if (curr == next_fwd(prev)) begin
      r.valid = 1'b1;
      r.dir   = 1'b1;
    end else if (prev == next_fwd(curr)) begin
      r.valid = 1'b1;
    end else if (curr != prev) begin
      r.illegal = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
// f follows s only after FILTER consecutive mismatching samples.
module phase_filter #(
  parameter int FILTER = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic x_in,
  output logic f
);

  localparam logic [3:0] LIM = 4'(FILTER - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       f_q, f_d;
  logic [3:0] cnt_q, cnt_d;

  // filter: count mismatching cycles, accept on the FILTER-th
  always_comb begin
    sync1_d = x_in;
    sync2_d = sync1_q;
    f_d     = f_q;
    cnt_d   = '0;
    if (sync2_q != f_q) begin
      if (cnt_q == LIM) begin
        f_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      f_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f = f_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases to step/dir strobes,
// a loadable position counter, wrap pulse and sticky error.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FILTER = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             err_clr,
  output logic             step_en,
  output logic             step_dir,
  output logic [WIDTH-1:0] position,
  output logic             wrap,
  output logic             err
);

  localparam logic [4:0] INIT_LAST = 5'(FILTER + 2);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic a_f, b_f;
  logic [1:0] cur;
  step_t dec;

  fsm_t             state_q, state_d;
  logic [4:0]       icnt_q, icnt_d;
  logic [1:0]       ref_q, ref_d;
  logic             step_en_q, step_en_d;
  logic             step_dir_q, step_dir_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pos_q, pos_d;

  phase_filter #(.FILTER(FILTER)) u_fa (
    .clk (clk),
    .rst (rst),
    .x_in(a_in),
    .f   (a_f)
  );

  phase_filter #(.FILTER(FILTER)) u_fb (
    .clk (clk),
    .rst (rst),
    .x_in(b_in),
    .f   (b_f)
  );

  assign cur = {a_f, b_f};
  assign dec = step_decode(ref_q, cur);

  // next state: settle in INIT, then track forever
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    unique case (state_q)
      INIT: begin
        icnt_d = icnt_q + 5'd1;
        if (icnt_q == INIT_LAST) state_d = TRACK;
      end
      TRACK: icnt_d = icnt_q;
      default: state_d = INIT;
    endcase
  end

  // outputs: reference, strobes, position and flags
  always_comb begin
    ref_d      = ref_q;
    step_en_d  = 1'b0;
    step_dir_d = step_dir_q;
    wrap_d     = 1'b0;
    err_d      = err_clr ? 1'b0 : err_q;
    pos_d      = pos_q;
    if (state_q == INIT) begin
      if (icnt_q == INIT_LAST) ref_d = cur;
    end else begin
      if (dec.valid || dec.illegal) ref_d = cur;
      if (dec.valid) begin
        step_en_d  = 1'b1;
        step_dir_d = dec.dir;
      end
      if (dec.illegal) err_d = 1'b1;
    end
    if (load) begin
      pos_d = load_value;
    end else if (step_en_d && dec.dir) begin
      pos_d  = pos_q + ONE;
      wrap_d = (pos_q == '1);
    end else if (step_en_d) begin
      pos_d  = pos_q - ONE;
      wrap_d = (pos_q == '0);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      icnt_q     <= '0;
      ref_q      <= PH00;
      step_en_q  <= 1'b0;
      step_dir_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      ref_q      <= ref_d;
      step_en_q  <= step_en_d;
      step_dir_q <= step_dir_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
    end
  end

  assign step_en  = step_en_q;
  assign step_dir = step_dir_q;
  assign wrap     = wrap_q;
  assign err      = err_q;
  assign position = pos_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8, FILTER=2).
// Inputs change on falling edges; outputs checked there too.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       err_clr = 1'b0;
  logic       step_en, step_dir, wrap, err;
  logic [7:0] position;

  int nvec = 0;
  int nerr = 0;
  int steps = 0;
  int ups = 0;
  int wraps = 0;
  int s0, u0, w0;

  quad_decoder #(.WIDTH(8), .FILTER(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .load      (load),
    .load_value(load_value),
    .err_clr   (err_clr),
    .step_en   (step_en),
    .step_dir  (step_dir),
    .position  (position),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step_en) begin
      steps = steps + 1;
      if (step_dir) ups = ups + 1;
    end
    if (wrap) wraps = wraps + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ph(input logic a, input logic b, input int n);
    a_in = a;
    b_in = b;
    tick(n);
  endtask

  task automatic snap();
    s0 = steps;
    u0 = ups;
    w0 = wraps;
  endtask

  initial begin
    tick(3);
    chk("rst_pos", 32'(position), 32'h0);
    chk("rst_step", 32'(step_en), 32'h0);
    chk("rst_dir", 32'(step_dir), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick(10);

    snap();
    ph(1, 0, 6);
    ph(1, 1, 6);
    ph(0, 1, 6);
    ph(0, 0, 6);
    chk("fwd_steps", 32'(steps - s0), 32'd4);
    chk("fwd_ups", 32'(ups - u0), 32'd4);
    chk("fwd_pos", 32'(position), 32'd4);
    chk("fwd_err", 32'(err), 32'h0);

    load = 1'b1;
    load_value = 8'hFF;
    tick(1);
    load = 1'b0;
    chk("load_pos", 32'(position), 32'hFF);
    snap();
    ph(1, 0, 6);
    chk("wrap_up_pos", 32'(position), 32'h00);
    chk("wrap_up_cnt", 32'(wraps - w0), 32'd1);
    ph(0, 0, 6);
    chk("wrap_dn_pos", 32'(position), 32'hFF);
    chk("wrap_dn_cnt", 32'(wraps - w0), 32'd2);
    chk("wrap_dn_dir", 32'(step_dir), 32'h0);

    snap();
    ph(1, 0, 1);
    ph(0, 0, 8);
    chk("glitch_steps", 32'(steps - s0), 32'd0);
    chk("glitch_pos", 32'(position), 32'hFF);
    ph(1, 0, 3);
    ph(0, 0, 8);
    chk("pulse3_steps", 32'(steps - s0), 32'd2);
    chk("pulse3_pos", 32'(position), 32'hFF);

    snap();
    ph(1, 1, 6);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_steps", 32'(steps - s0), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 32'h0);
    ph(0, 0, 4);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("setwins_err", 32'(err), 32'h1);
    chk("setwins_steps", 32'(steps - s0), 32'd0);
    tick(3);
    chk("setwins_hold", 32'(err), 32'h1);

    a_in = 1'b1;
    b_in = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    snap();
    tick(10);
    chk("init_steps", 32'(steps - s0), 32'd0);
    chk("init_err", 32'(err), 32'h0);
    chk("init_pos", 32'(position), 32'h0);
    ph(0, 1, 6);
    chk("init_mv_steps", 32'(steps - s0), 32'd1);
    chk("init_mv_dir", 32'(step_dir), 32'h1);
    chk("init_mv_pos", 32'(position), 32'h1);

    ph(0, 0, 6);
    ph(1, 0, 6);
    ph(1, 1, 6);
    ph(0, 1, 6);
    chk("pre_rst_pos", 32'(position), 32'h5);
    ph(0, 0, 3);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_pos", 32'(position), 32'h0);
    chk("mid_rst_step", 32'(step_en), 32'h0);
    chk("mid_rst_wrap", 32'(wrap), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    snap();
    tick(12);
    chk("mid_rst_nostep", 32'(steps - s0), 32'd0);
    chk("mid_rst_pos2", 32'(position), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
